// File: rtl/omux_ft_writer_if.sv
// Producer-side omux handshake plus the FT2232 transmit pins of omux_ft_writer.
interface omux_ft_writer_if #(
  parameter int SRC_COUNT = 2
);
  logic [SRC_COUNT-1:0]   src_req_i;
  logic [8*SRC_COUNT-1:0] src_data_i;
  logic [SRC_COUNT-1:0]   src_sel_o;
  logic                   ntxe_i;
  logic                   wr_o;
  logic [7:0]             d_o;
  logic                   d_oe_o;
  logic                   si_o;
  logic                   busy_o;
  logic [31:0]            tx_count_o;

  modport slave (
    input  src_req_i, src_data_i, ntxe_i,
    output src_sel_o, wr_o, d_o, d_oe_o, si_o, busy_o, tx_count_o
  );

  modport master (
    output src_req_i, src_data_i, ntxe_i,
    input  src_sel_o, wr_o, d_o, d_oe_o, si_o, busy_o, tx_count_o
  );
endinterface

// File: rtl/omux_ft_writer.sv
// Round-robin omux arbiter + byte FIFO + FT2232 async-FIFO write strobe engine.
// Optional send-immediate flush after an idle packet gap: OMUX_SI_FLUSH_EN.
module omux_ft_writer #(
  parameter int SRC_COUNT      = 2,
  parameter int FIFO_DEPTH     = 16,
  parameter int WR_CYCLES      = 3,
  parameter int RECOVER_CYCLES = 4,
  parameter int SI_IDLE        = 64
) (
  input  logic              clk_i,
  input  logic              reset_i,
  omux_ft_writer_if.slave   bus
);
  localparam int GW   = (SRC_COUNT > 1) ? $clog2(SRC_COUNT) : 1;
  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int RLEN = RECOVER_CYCLES + 2;
  localparam int CMAX = (WR_CYCLES > RLEN) ? WR_CYCLES : RLEN;
  localparam int CW   = $clog2(CMAX + 1);

  if (SRC_COUNT < 1 || SRC_COUNT > 8 || FIFO_DEPTH < 4 ||
      (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || WR_CYCLES < 1 ||
      RECOVER_CYCLES < 0 || SI_IDLE < 1) begin : g_bad_param
    $error("omux_ft_writer: illegal parameter value");
  end

  typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, RECOVER} st_t;

  // ---------------- arbiter ----------------
  logic [GW-1:0]        ptr, grant, pick, cand;
  logic [GW:0]          sum;
  logic                 grant_valid, pick_vld;
  logic [SRC_COUNT-1:0] sel;
  logic                 push, pop, empty, full;
  logic [7:0]           din, head;

  always_comb begin
    pick     = '0;
    pick_vld = 1'b0;
    sum      = '0;
    cand     = '0;
    // descending scan so the lowest rotated index is the last one written
    for (int i = SRC_COUNT - 1; i >= 0; i--) begin
      sum = {1'b0, ptr} + (GW+1)'(i);
      if (sum >= (GW+1)'(SRC_COUNT)) sum = sum - (GW+1)'(SRC_COUNT);
      cand = sum[GW-1:0];
      if (bus.src_req_i[cand]) begin
        pick     = cand;
        pick_vld = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      grant_valid <= 1'b0;
      grant       <= '0;
      ptr         <= '0;
    end else if (!grant_valid) begin
      if (pick_vld) begin
        grant_valid <= 1'b1;
        grant       <= pick;
      end
    end else if (!bus.src_req_i[grant]) begin
      grant_valid <= 1'b0;
      ptr         <= (grant == GW'(SRC_COUNT - 1)) ? '0 : grant + 1'b1;
    end
  end

  always_comb begin
    sel = '0;
    if (grant_valid && bus.src_req_i[grant] && !full) sel[grant] = 1'b1;
  end

  assign bus.src_sel_o = sel;
  assign push          = |sel;
  assign din           = bus.src_data_i[{grant, 3'b000} +: 8];

  // ---------------- FWFT byte FIFO ----------------
  logic [7:0] mem [FIFO_DEPTH];
  logic [AW:0] wp, rp;

  assign empty = (wp == rp);
  assign full  = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  assign head  = mem[rp[AW-1:0]];

  always_ff @(posedge clk_i) begin
    if (push) mem[wp[AW-1:0]] <= din;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop)  rp <= rp + 1'b1;
    end
  end

  // ---------------- TXE# synchronizer ----------------
  logic txe_m, txe_s;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      txe_m <= 1'b1;
      txe_s <= 1'b1;
    end else begin
      txe_m <= bus.ntxe_i;
      txe_s <= txe_m;
    end
  end

  // ---------------- write FSM ----------------
  st_t         state, nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [7:0]  d_q;
  logic [31:0] tx_cnt;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state  <= IDLE;
      cnt    <= '0;
      d_q    <= '0;
      tx_cnt <= '0;
    end else begin
      state <= nxt;
      cnt   <= cnt_nxt;
      if (pop)            d_q    <= head;
      if (state == HOLD)  tx_cnt <= tx_cnt + 32'd1;
    end
  end

  // Recovery runs two extra cycles so a TXE# sample taken after the
  // recovery window has fully crossed the synchronizer before IDLE trusts it.
  always_comb begin
    nxt     = state;
    cnt_nxt = cnt;
    pop     = 1'b0;
    case (state)
      IDLE: if (!empty && !txe_s) begin
        pop = 1'b1;
        nxt = SETUP;
      end
      SETUP: begin
        nxt     = STROBE;
        cnt_nxt = CW'(WR_CYCLES - 1);
      end
      STROBE: begin
        if (cnt == '0) nxt = HOLD;
        else           cnt_nxt = cnt - 1'b1;
      end
      HOLD: begin
        nxt     = RECOVER;
        cnt_nxt = CW'(RLEN - 1);
      end
      RECOVER: begin
        if (cnt == '0) nxt = IDLE;
        else           cnt_nxt = cnt - 1'b1;
      end
      default: nxt = IDLE;
    endcase
  end

  assign bus.wr_o       = (state == STROBE);
  assign bus.d_oe_o     = (state == SETUP) || (state == STROBE) || (state == HOLD);
  assign bus.d_o        = d_q;
  assign bus.tx_count_o = tx_cnt;
  assign bus.busy_o     = grant_valid | ~empty | (state != IDLE);

  // ---------------- send-immediate flush ----------------
`ifdef OMUX_SI_FLUSH_EN
  localparam int SW = $clog2(SI_IDLE + 1);
  logic [SW-1:0] si_cnt;
  logic          si_armed, idle_now;
  logic [1:0]    si_pulse;

  assign idle_now = ~grant_valid & empty & (state == IDLE);

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      si_cnt   <= '0;
      si_armed <= 1'b0;
      si_pulse <= '0;
    end else begin
      if (si_pulse != 2'd0) si_pulse <= si_pulse - 2'd1;
      if (push) begin
        si_armed <= 1'b1;
        si_cnt   <= '0;
      end else if (si_armed && idle_now) begin
        if (si_cnt == SW'(SI_IDLE - 1)) begin
          si_armed <= 1'b0;
          si_cnt   <= '0;
          si_pulse <= 2'd2;
        end else begin
          si_cnt <= si_cnt + 1'b1;
        end
      end else begin
        si_cnt <= '0;
      end
    end
  end

  assign bus.si_o = (si_pulse == 2'd0);
`else
  assign bus.si_o = 1'b1;
`endif
endmodule
